// File: rtl/uart_alu_sequencer_pkg.sv
// Shared definitions for the UART-to-ALU sequencer: ALU opcodes and FSM states.
package uart_alu_sequencer_pkg;

  // ALU opcode encodings (low six bits of the received opcode byte)
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  // Sequencer FSM states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_e;

endpackage

// File: rtl/uart_alu_sequencer_if.sv
// Bundle of the UART receive/transmit strobes and the ALU operand/result bus.
//
// Handshake semantics: there is no backpressure anywhere on this bus.
// rx_done is a one-cycle valid strobe qualifying rx_data; the sequencer always
// "accepts" it (using the byte in IDLE/WAIT_B/WAIT_OP, dropping it and raising
// overrun otherwise). tx_start is a one-cycle valid strobe qualifying tx_data,
// and tx_done is the transmitter's one-cycle completion strobe, which only has
// meaning while the sequencer waits for it.
interface uart_alu_sequencer_if #(
  parameter int DBIT     = 8,
  parameter int OP_WIDTH = 6
);
  logic [DBIT-1:0]     rx_data;
  logic                rx_done;
  logic                tx_done;
  logic [DBIT-1:0]     alu_result;
  logic [DBIT-1:0]     alu_a;
  logic [DBIT-1:0]     alu_b;
  logic [OP_WIDTH-1:0] alu_op;
  logic                tx_start;
  logic [DBIT-1:0]     tx_data;
  logic                busy;
  logic                frame_error;
  logic                overrun;

  // Sequencer side
  modport master (
    input  rx_data, rx_done, tx_done, alu_result,
    output alu_a, alu_b, alu_op, tx_start, tx_data, busy, frame_error, overrun
  );

  // UART/ALU environment side
  modport slave (
    output rx_data, rx_done, tx_done, alu_result,
    input  alu_a, alu_b, alu_op, tx_start, tx_data, busy, frame_error, overrun
  );
endinterface

// File: rtl/uart_alu_sequencer_frame_timeout.sv
// Inter-byte timeout: counts enabled cycles since the last accepted byte and
// flags expiry when the count reaches TIMEOUT-1. TIMEOUT=0 disables it.
module frame_timeout #(
  parameter int TIMEOUT = 50000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int            CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] C_MAX  = '1;
  localparam logic [CW-1:0] C_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] r_count;

  // Saturating cycle counter, cleared by reset or an accepted byte
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != C_MAX)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = (TIMEOUT != 0) && i_enable && (r_count == C_LAST);

endmodule

// File: rtl/uart_alu_sequencer.sv
// Collects operand A, operand B and opcode bytes from uart_rx, presents them
// to the external ALU, captures the result and hands it to uart_tx.
module uart_alu_sequencer
  import uart_alu_sequencer_pkg::*;
#(
  parameter int DBIT     = 8,
  parameter int OP_WIDTH = 6,
  parameter int TIMEOUT  = 50000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  uart_alu_sequencer_if.master  io_bus,
  output state_e                o_state
);
  state_e              r_state;
  logic [DBIT-1:0]     r_alu_a;
  logic [DBIT-1:0]     r_alu_b;
  logic [OP_WIDTH-1:0] r_alu_op;
  logic [DBIT-1:0]     r_tx_data;
  logic                r_tx_start;
  logic                r_frame_error;
  logic                r_overrun;

  logic w_collecting;
  logic w_accept;
  logic w_expired;
  logic w_unused;

  // Timeout only runs while a frame is partially received
  assign w_collecting = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
  assign w_accept     = io_bus.rx_done && ((r_state == ST_IDLE) || w_collecting);
  // Opcode byte bits above OP_WIDTH carry no meaning
  assign w_unused     = &{1'b0, io_bus.rx_data[DBIT-1:OP_WIDTH]};

  frame_timeout #(.TIMEOUT(TIMEOUT)) u_frame_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (w_accept),
    .i_enable  (w_collecting),
    .o_expired (w_expired)
  );

  // Sequencer FSM with registered outputs; an arriving byte beats timeout expiry
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_tx_data     <= '0;
      r_tx_start    <= 1'b0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_tx_start    <= 1'b0;
      r_frame_error <= 1'b0;
      r_overrun     <= io_bus.rx_done &&
                       (r_state inside {ST_EXEC, ST_SEND, ST_WAIT_TX});
      case (r_state)
        ST_IDLE: begin
          if (io_bus.rx_done) begin
            r_alu_a <= io_bus.rx_data;
            r_state <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (io_bus.rx_done) begin
            r_alu_b <= io_bus.rx_data;
            r_state <= ST_WAIT_OP;
          end else if (w_expired) begin
            r_frame_error <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        ST_WAIT_OP: begin
          if (io_bus.rx_done) begin
            r_alu_op <= io_bus.rx_data[OP_WIDTH-1:0];
            r_state  <= ST_EXEC;
          end else if (w_expired) begin
            r_frame_error <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          r_tx_data  <= io_bus.alu_result;
          r_tx_start <= 1'b1;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          r_state <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (io_bus.tx_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_bus.alu_a       = r_alu_a;
  assign io_bus.alu_b       = r_alu_b;
  assign io_bus.alu_op      = r_alu_op;
  assign io_bus.tx_data     = r_tx_data;
  assign io_bus.tx_start    = r_tx_start;
  assign io_bus.frame_error = r_frame_error;
  assign io_bus.overrun     = r_overrun;
  assign io_bus.busy        = (r_state != ST_IDLE);
  assign o_state            = r_state;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed bench for uart_alu_sequencer with a behavioural ALU and a
// result scoreboard fed when each opcode byte is sent.
module tb_uart_alu_sequencer;
  import uart_alu_sequencer_pkg::*;

  localparam int DBIT = 8;
  localparam int OPW  = 6;
  localparam int TMO  = 20;

  logic   clk     = 1'b0;
  logic   reset_n = 1'b0;
  state_e dbg_state;
  int     n_cmp = 0;
  int     n_err = 0;
  logic [DBIT-1:0] exp_q[$];

  uart_alu_sequencer_if #(.DBIT(DBIT), .OP_WIDTH(OPW)) bus ();

  uart_alu_sequencer #(.DBIT(DBIT), .OP_WIDTH(OPW), .TIMEOUT(TMO)) dut (
    .i_clk   (clk),
    .i_reset (reset_n),
    .io_bus  (bus),
    .o_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- external ALU ----------------
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return $signed(a) >>> b;
      OP_SRL:  return a >> b;
      OP_NOR:  return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign bus.alu_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every tx_start must match the oldest pending expectation
  always @(negedge clk) begin
    if (reset_n && bus.tx_start) begin
      chk("sb_has_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("sb_tx_data", bus.tx_data, exp_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
  endtask

  task automatic finish_frame(input logic [7:0] op, input logic [7:0] e, input string tag);
    exp_q.push_back(e);
    send_byte(op);
    chk({tag, "_exec_state"}, dbg_state, ST_EXEC);
    chk({tag, "_exec_no_start"}, bus.tx_start, 1'b0);
    @(negedge clk);
    chk({tag, "_start_pulse"}, bus.tx_start, 1'b1);
    @(negedge clk);
    chk({tag, "_start_one_cycle"}, bus.tx_start, 1'b0);
    chk({tag, "_wait_tx_state"}, dbg_state, ST_WAIT_TX);
    chk({tag, "_tx_data_stable"}, bus.tx_data, e);
    chk({tag, "_busy_wait_tx"}, bus.busy, 1'b1);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic [7:0] e, input string tag);
    send_byte(a);
    send_byte(b);
    finish_frame(op, e, tag);
  endtask

  task automatic tx_ack(input string tag);
    @(negedge clk);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    chk({tag, "_busy_after_tx_done"}, bus.busy, 1'b0);
    chk({tag, "_idle_after_tx_done"}, dbg_state, ST_IDLE);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_alu_a"}, bus.alu_a, 8'h00);
    chk({tag, "_alu_b"}, bus.alu_b, 8'h00);
    chk({tag, "_alu_op"}, bus.alu_op, 6'h00);
    chk({tag, "_tx_data"}, bus.tx_data, 8'h00);
    chk({tag, "_tx_start"}, bus.tx_start, 1'b0);
    chk({tag, "_frame_error"}, bus.frame_error, 1'b0);
    chk({tag, "_overrun"}, bus.overrun, 1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [1:0] rhi;
    bus.rx_data = '0;
    bus.rx_done = 1'b0;
    bus.tx_done = 1'b0;
    reset_n     = 1'b0;
    repeat (3) @(negedge clk);
    chk_cleared("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // ADD 5+3
    run_frame(8'h05, 8'h03, 8'h20, 8'h08, "add");
    chk("add_alu_a", bus.alu_a, 8'h05);
    chk("add_alu_b", bus.alu_b, 8'h03);
    chk("add_alu_op", bus.alu_op, 6'h20);
    tx_ack("add");

    // SUB with borrow, then SRA with opcode upper bits set
    run_frame(8'h03, 8'h05, 8'h22, 8'hFE, "sub");
    tx_ack("sub");
    run_frame(8'hF0, 8'h02, 8'hC3, 8'hFC, "sra");
    chk("sra_op_masked", bus.alu_op, 6'h03);
    tx_ack("sra");

    // Timeout after operand A, registers retained
    send_byte(8'h11);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_not_yet_error", bus.frame_error, 1'b0);
    chk("tmo_not_yet_busy", bus.busy, 1'b1);
    @(negedge clk);
    chk("tmo_frame_error", bus.frame_error, 1'b1);
    chk("tmo_idle", dbg_state, ST_IDLE);
    chk("tmo_alu_a_kept", bus.alu_a, 8'h11);
    @(negedge clk);
    chk("tmo_error_one_cycle", bus.frame_error, 1'b0);
    run_frame(8'h0F, 8'hF0, 8'h25, 8'hFF, "or");
    tx_ack("or");

    // Overrun during WAIT_TX
    run_frame(8'h10, 8'h20, 8'h25, 8'h30, "ovr");
    send_byte(8'h77);
    chk("ovr_pulse", bus.overrun, 1'b1);
    chk("ovr_state_held", dbg_state, ST_WAIT_TX);
    @(negedge clk);
    chk("ovr_one_cycle", bus.overrun, 1'b0);
    tx_ack("ovr");
    run_frame(8'h09, 8'h04, 8'h22, 8'h05, "post_ovr");
    chk("post_ovr_alu_a", bus.alu_a, 8'h09);
    tx_ack("post_ovr");

    // Reset while in WAIT_OP
    send_byte(8'h11);
    send_byte(8'h22);
    chk("rst_mid_wait_op", dbg_state, ST_WAIT_OP);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk_cleared("rst_mid");
    run_frame(8'h0C, 8'h0A, 8'h26, 8'h06, "xor");
    tx_ack("xor");

    // Random ADD frames with random ignored opcode bits
    for (int i = 0; i < 4; i++) begin
      ra  = 8'($urandom_range(1, 100));
      rb  = 8'($urandom_range(1, 100));
      rhi = 2'($urandom_range(0, 3));
      run_frame(ra, rb, {rhi, OP_ADD}, ra + rb, "rand_add");
      tx_ack("rand_add");
    end

    // Operand B coincident with timeout expiry, then undefined opcode
    send_byte(8'h5A);
    repeat (TMO - 2) @(negedge clk);
    send_byte(8'h33);
    chk("coinc_no_error", bus.frame_error, 1'b0);
    chk("coinc_wait_op", dbg_state, ST_WAIT_OP);
    chk("coinc_alu_b", bus.alu_b, 8'h33);
    finish_frame(8'h3F, 8'h00, "undef");
    tx_ack("undef");

    @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
